fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a single-outstanding-request instruction memory
// port and fills the IF/ID pipeline register, handling stall, flush and redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [11:0] id_immediate,
    output logic [1:0]  fsm_state
);

    // Handshake: a request is live while imem_req=1 and imem_addr stays fixed;
    // imem_ready=1 in a cycle returns imem_rdata and retires that request.

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] hold_instr, hold_nxt;
    logic        id_valid_nxt;
    logic [31:0] id_pc_nxt, id_instr_nxt;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = redirect_pc & 32'hFFFF_FFFC;
    // Outside DISCARD req_addr always equals pc, so pc+4 is also the next request.
    assign pc_inc = pc + 32'd4;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        hold_nxt     = hold_instr;
        id_valid_nxt = id_valid & ~flush;
        id_pc_nxt    = id_pc;
        id_instr_nxt = id_instr;
        if (redirect_valid) begin
            id_valid_nxt = 1'b0;
            pc_nxt       = target;
            case (state)
                HOLD: begin
                    req_addr_nxt = target;
                    state_nxt    = FETCH;
                end
                default: begin
                    // An unanswered request must stay on the bus until memory responds.
                    if (imem_ready) begin
                        req_addr_nxt = target;
                        state_nxt    = FETCH;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            hold_nxt  = imem_rdata;
                            state_nxt = HOLD;
                        end else begin
                            id_valid_nxt = 1'b1;
                            id_pc_nxt    = req_addr;
                            id_instr_nxt = imem_rdata;
                            pc_nxt       = pc_inc;
                            req_addr_nxt = pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid_nxt = 1'b1;
                        id_pc_nxt    = req_addr;
                        id_instr_nxt = hold_instr;
                        pc_nxt       = pc_inc;
                        req_addr_nxt = pc_inc;
                        state_nxt    = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ready) begin
                        req_addr_nxt = pc;
                        state_nxt    = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            hold_instr <= NOP;
            id_valid   <= 1'b0;
            id_pc      <= 32'h00000000;
            id_instr   <= NOP;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            req_addr   <= req_addr_nxt;
            hold_instr <= hold_nxt;
            id_valid   <= id_valid_nxt;
            id_pc      <= id_pc_nxt;
            id_instr   <= id_instr_nxt;
        end
    end

    assign imem_req     = (state != HOLD) && !reset;
    assign imem_addr    = req_addr;
    assign id_opcode    = id_instr[6:0];
    assign id_rd        = id_instr[11:7];
    assign id_immediate = id_instr[31:20];
    assign fsm_state    = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [11:0] id_immediate;
    logic [1:0]  fsm_state;

    fetch_stage #(.RESET_PC(32'h00000000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_immediate(id_immediate),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_check = 0;
    int n_fail  = 0;

    // Model of the fetch pipeline in terms of what is on the bus and in IF/ID.
    logic [31:0] m_pc, m_addr, m_hold_word, m_idpc, m_idinstr;
    logic        m_held, m_stale, m_idv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd8) return 32'h00500093;
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_check++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_hold_word = 32'h13;
        m_held = 1'b0; m_stale = 1'b0;
        m_idv = 1'b0; m_idpc = 32'h0; m_idinstr = 32'h00000013;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_idv = 1'b1; m_idpc = m_addr; m_idinstr = w;
        m_pc = m_addr + 32'd4;
        m_addr = m_pc;
    endtask

    task automatic model_step(input logic rdy, input logic st, input logic fl,
                              input logic rv, input logic [31:0] rpc);
        logic [31:0] word;
        logic        loaded;
        word = mem_word(m_addr);
        loaded = 1'b0;
        if (rv) begin
            m_stale = !m_held && !rdy;
            m_pc = rpc & 32'hFFFF_FFFC;
            if (!m_stale) m_addr = m_pc;
            m_held = 1'b0;
            m_idv = 1'b0;
        end else if (m_stale) begin
            if (rdy) begin m_stale = 1'b0; m_addr = m_pc; end
        end else if (m_held) begin
            if (!st) begin deliver(m_hold_word); loaded = 1'b1; m_held = 1'b0; end
        end else if (rdy) begin
            if (st) begin m_held = 1'b1; m_hold_word = word; end
            else begin deliver(word); loaded = 1'b1; end
        end
        if (fl && !loaded) m_idv = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".imem_req"}, {31'b0, imem_req}, {31'b0, !m_held});
        chk({where, ".imem_addr"}, imem_addr, m_addr);
        chk({where, ".id_valid"}, {31'b0, id_valid}, {31'b0, m_idv});
        chk({where, ".id_pc"}, id_pc, m_idpc);
        chk({where, ".id_instr"}, id_instr, m_idinstr);
        chk({where, ".id_opcode"}, {25'b0, id_opcode}, {25'b0, m_idinstr[6:0]});
        chk({where, ".id_rd"}, {27'b0, id_rd}, {27'b0, m_idinstr[11:7]});
        chk({where, ".id_imm"}, {20'b0, id_immediate}, {20'b0, m_idinstr[31:20]});
    endtask

    // Entered and left at posedge+1: drive, check, then advance one edge.
    task automatic cycle(input string where, input logic rdy, input logic st,
                         input logic fl, input logic rv, input logic [31:0] rpc);
        imem_ready = rdy; stall = st; flush = fl;
        redirect_valid = rv; redirect_pc = rpc;
        imem_rdata = mem_word(m_addr);
        #1;
        check_outputs(where);
        model_step(rdy, st, fl, rv, rpc);
        n_vec++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ".imem_req"}, {31'b0, imem_req}, 32'd0);
        chk({where, ".imem_addr"}, imem_addr, 32'h00000000);
        chk({where, ".id_valid"}, {31'b0, id_valid}, 32'd0);
        chk({where, ".id_pc"}, id_pc, 32'h00000000);
        chk({where, ".id_instr"}, id_instr, 32'h00000013);
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        model_reset();
        #3;
        check_reset_values("por");
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Streaming: one instruction per cycle from RESET_PC
        for (int i = 0; i < 4; i++) cycle("stream", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("stream_last_pc", id_pc, 32'd12);

        // Stall into the hold buffer at address 8, then release it
        cycle("redir8", 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000008);
        cycle("stall_cap", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("stall_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("stall_rel", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("hold_instr", id_instr, 32'h00500093);
        chk("hold_pc", id_pc, 32'd8);
        chk("hold_imm", {20'b0, id_immediate}, 32'h005);
        chk("hold_rd", {27'b0, id_rd}, 32'd1);
        chk("hold_opcode", {25'b0, id_opcode}, 32'h13);

        // Flush together with stall kills IF/ID but leaves the fetch address alone
        cycle("flush_stall", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_addr", imem_addr, 32'd12);

        // Redirect while memory is busy: old request held, its response dropped
        cycle("discard_in", 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000103);
        chk("discard_addr_held", imem_addr, 32'd12);
        cycle("discard_wait", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("discard_drop", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("discard_new_addr", imem_addr, 32'h00000100);
        chk("discard_no_valid", {31'b0, id_valid}, 32'd0);

        // PC wraps modulo 2^32
        cycle("wrap_redir", 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
        chk("wrap_addr_hi", imem_addr, 32'hFFFFFFFC);
        cycle("wrap_a", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr_lo", imem_addr, 32'h00000000);
        cycle("wrap_b", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a DISCARD
        cycle("pre_rst", 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000040);
        imem_ready = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
        reset = 1'b1;
        #2;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_addr", imem_addr, 32'h00000000);
        cycle("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_rdy, r_st, r_fl, r_rv;
            logic [31:0] r_pc;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_fl  = ($urandom_range(0, 7) == 0);
            r_rv  = ($urandom_range(0, 9) == 0);
            r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15)))
                                                : $urandom;
            cycle("rand", r_rdy, r_st, r_fl, r_rv, r_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
